// File: rtl/bitcoin_job_host.sv
`default_nettype none
// ============================================================================
// Module  : bitcoin_job_host
// Purpose : Loads a block header into shared memory, kicks the hasher, then
//           scans its result words for the minimum hash and checks the target.
// Rev     : 1.0
// ============================================================================
module bitcoin_job_host #(
  parameter int NUM_NONCES     = 16,
  parameter int HEADER_WORDS   = 19,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int NW = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          job_start,
  input  logic [15:0]   header_addr,
  input  logic [15:0]   hash_out_addr,
  input  logic [31:0]   target,
  input  logic          hdr_valid,
  input  logic [31:0]   hdr_data,
  output logic          hdr_ready,
  output logic          hash_start,
  input  logic          hash_done,
  output logic          mem_we,
  output logic [15:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy,
  output logic          result_valid,
  output logic          found,
  output logic [NW-1:0] best_nonce,
  output logic [31:0]   best_hash,
  output logic          timeout
);

  localparam int HW = $clog2(HEADER_WORDS + 1);
  localparam int RW = $clog2(NUM_NONCES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_KICK      = 3'd2,
    S_WAIT_LOW  = 3'd3,
    S_WAIT_HIGH = 3'd4,
    S_READ      = 3'd5,
    S_REPORT    = 3'd6
  } state_t;

  state_t          r_state, w_state_next;
  logic [15:0]     r_hdr_base, r_out_base;
  logic [31:0]     r_target;
  logic [HW-1:0]   r_word_cnt;
  logic [RW-1:0]   r_rd_cnt;
  logic [TW-1:0]   r_to_cnt;
  logic [31:0]     r_run_hash;
  logic [NW-1:0]   r_run_idx;
  logic            r_wr_we;
  logic [15:0]     r_wr_addr;
  logic [31:0]     r_wr_data;
  logic            r_found, r_timeout;
  logic [NW-1:0]   r_best_nonce;
  logic [31:0]     r_best_hash;

  logic            w_accept, w_consume, w_expired, w_issue;
  logic [31:0]     w_run_hash;
  logic [NW-1:0]   w_run_idx;

  always_comb begin
    w_state_next = r_state;
    w_accept     = (r_state == S_LOAD) && hdr_valid;
    w_consume    = (r_state == S_READ) && (r_rd_cnt != '0);
    w_issue      = (r_state == S_READ) && (r_rd_cnt < RW'(NUM_NONCES));
    w_expired    = (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
    w_run_hash   = r_run_hash;
    w_run_idx    = r_run_idx;
    // First consumed word seeds the minimum; strict compare keeps the lower index on ties.
    if (w_consume && ((r_rd_cnt == RW'(1)) || (mem_rdata < r_run_hash))) begin
      w_run_hash = mem_rdata;
      w_run_idx  = NW'(r_rd_cnt - RW'(1));
    end
    case (r_state)
      S_IDLE:      if (job_start) w_state_next = S_LOAD;
      S_LOAD:      if (w_accept && (r_word_cnt == HW'(HEADER_WORDS - 1))) w_state_next = S_KICK;
      S_KICK:      w_state_next = S_WAIT_LOW;
      S_WAIT_LOW:  if (w_expired) w_state_next = S_REPORT;
                   else if (!hash_done) w_state_next = S_WAIT_HIGH;
      S_WAIT_HIGH: if (w_expired) w_state_next = S_REPORT;
                   else if (hash_done) w_state_next = S_READ;
      S_READ:      if (r_rd_cnt == RW'(NUM_NONCES)) w_state_next = S_REPORT;
      S_REPORT:    w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_hdr_base   <= '0;
      r_out_base   <= '0;
      r_target     <= '0;
      r_word_cnt   <= '0;
      r_rd_cnt     <= '0;
      r_to_cnt     <= '0;
      r_run_hash   <= '0;
      r_run_idx    <= '0;
      r_wr_we      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_found      <= 1'b0;
      r_timeout    <= 1'b0;
      r_best_nonce <= '0;
      r_best_hash  <= '0;
    end else begin
      r_state <= w_state_next;
      r_wr_we <= w_accept;
      if (w_accept) begin
        r_wr_addr  <= r_hdr_base + 16'(r_word_cnt);
        r_wr_data  <= hdr_data;
        r_word_cnt <= r_word_cnt + HW'(1);
      end
      if ((r_state == S_IDLE) && job_start) begin
        r_hdr_base <= header_addr;
        r_out_base <= hash_out_addr;
        r_target   <= target;
        r_word_cnt <= '0;
      end
      if (r_state == S_KICK) begin
        r_to_cnt <= '0;
        r_rd_cnt <= '0;
      end
      if ((r_state == S_WAIT_LOW) || (r_state == S_WAIT_HIGH)) begin
        r_to_cnt <= r_to_cnt + TW'(1);
        if (w_state_next == S_REPORT) begin
          r_found      <= 1'b0;
          r_timeout    <= 1'b1;
          r_best_nonce <= '0;
          r_best_hash  <= '0;
        end
      end
      if (r_state == S_READ) begin
        r_rd_cnt   <= r_rd_cnt + RW'(1);
        r_run_hash <= w_run_hash;
        r_run_idx  <= w_run_idx;
        if (w_state_next == S_REPORT) begin
          r_found      <= (w_run_hash < r_target);
          r_timeout    <= 1'b0;
          r_best_nonce <= w_run_idx;
          r_best_hash  <= w_run_hash;
        end
      end
    end
  end

  assign hdr_ready    = (r_state == S_LOAD);
  assign hash_start   = (r_state == S_KICK);
  assign busy         = (r_state != S_IDLE);
  assign result_valid = (r_state == S_REPORT);
  assign mem_we       = r_wr_we;
  assign mem_wdata    = r_wr_data;
  // Read addresses are driven combinationally so word 0 is presented in the first READ cycle.
  assign mem_addr     = w_issue ? (r_out_base + 16'(r_rd_cnt)) : r_wr_addr;
  assign found        = r_found;
  assign timeout      = r_timeout;
  assign best_nonce   = r_best_nonce;
  assign best_hash    = r_best_hash;

endmodule
`default_nettype wire

// File: tb/tb_bitcoin_job_host.sv
`default_nettype none
`timescale 1ns/1ps
// Scoreboard bench for bitcoin_job_host: memory model, hasher model, queued expectations.
module tb_bitcoin_job_host;
  localparam int N  = 16;
  localparam int TO = 8;
  localparam int H  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        job_start = 1'b0;
  logic [15:0] header_addr = '0, hash_out_addr = '0;
  logic [31:0] target = '0;
  logic        hdr_valid = 1'b0;
  logic [31:0] hdr_data = '0;
  logic        hdr_ready, hash_start, hash_done, mem_we, busy, result_valid, found, timeout;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, best_hash;
  logic [31:0] mem_rdata = '0;
  logic [3:0]  best_nonce;

  always #5 clk = ~clk;

  bitcoin_job_host #(.NUM_NONCES(N), .HEADER_WORDS(19), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .job_start(job_start), .header_addr(header_addr),
    .hash_out_addr(hash_out_addr), .target(target), .hdr_valid(hdr_valid),
    .hdr_data(hdr_data), .hdr_ready(hdr_ready), .hash_start(hash_start),
    .hash_done(hash_done), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .result_valid(result_valid), .found(found),
    .best_nonce(best_nonce), .best_hash(best_hash), .timeout(timeout)
  );

  // Shared memory: DUT port plus a bench preload port; one-cycle read latency.
  logic [31:0] mem [0:65535];
  logic        pl_we = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (pl_we)  mem[pl_addr]  <= pl_data;
    mem_rdata <= mem[mem_addr];
  end

  // Hasher: done drops for H cycles after a start pulse.
  logic hasher_en = 1'b1;
  int   busy_cnt = 0;
  always @(posedge clk) begin
    if (hash_start && hasher_en) busy_cnt <= H;
    else if (busy_cnt != 0)      busy_cnt <= busy_cnt - 1;
  end
  assign hash_done = (busy_cnt == 0);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic fnd; logic [3:0] nonce; logic [31:0] hash; logic to; int lat; } res_t;
  wr_t  wq[$];
  res_t rq[$];

  int errors = 0, checks = 0, results_seen = 0, kicks = 0, kick_cyc = 0;
  logic prev_rv = 1'b0;
  logic [15:0] exp_kick_addr = '0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT writes, kicks or reports.
  always @(negedge clk) begin
    if (reset) begin
      kicks   = 0;
      prev_rv = 1'b0;
    end else begin
      if (prev_rv) chk("busy_after_report", {63'd0, busy}, 64'd0);
      if (mem_we) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %0h data %0h, none expected", mem_addr, mem_wdata);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", {48'd0, mem_addr}, {48'd0, w.addr});
          chk("wr_data", {32'd0, mem_wdata}, {32'd0, w.data});
        end
      end
      if (hash_start) begin
        kicks++;
        kick_cyc = cyc;
        chk("kick_last_write", {47'd0, mem_we, mem_addr}, {47'd0, 1'b1, exp_kick_addr});
      end
      if (result_valid) begin
        chk("rv_width", {63'd0, prev_rv}, 64'd0);
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: found %0b nonce %0d, none expected", found, best_nonce);
        end else begin
          res_t r;
          r = rq.pop_front();
          chk("found", {63'd0, found}, {63'd0, r.fnd});
          chk("best_nonce", {60'd0, best_nonce}, {60'd0, r.nonce});
          chk("best_hash", {32'd0, best_hash}, {32'd0, r.hash});
          chk("timeout", {63'd0, timeout}, {63'd0, r.to});
          chk("latency", 64'(cyc - kick_cyc), 64'(r.lat));
          chk("kick_count", 64'(kicks), 64'd1);
        end
        kicks = 0;
        results_seen++;
      end
      prev_rv = result_valid;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [15:0] base, input logic [31:0] v [N]);
    for (int j = 0; j < N; j++) begin
      pl_we = 1'b1; pl_addr = base + 16'(j); pl_data = v[j];
      tick();
    end
    pl_we = 1'b0;
  endtask

  task automatic start_job(input logic [15:0] hb, input logic [15:0] ob, input logic [31:0] tg);
    job_start = 1'b1; header_addr = hb; hash_out_addr = ob; target = tg;
    exp_kick_addr = hb + 16'd18;
    tick();
    job_start = 1'b0;
  endtask

  task automatic send_header(input logic [15:0] hb, input logic [31:0] hval, input bit toggle);
    for (int i = 0; i < 19; i++) begin
      hdr_valid = 1'b1; hdr_data = hval + 32'(i);
      wq.push_back('{addr: hb + 16'(i), data: hval + 32'(i)});
      tick();
      if (toggle && i < 18) begin
        hdr_valid = 1'b0; hdr_data = 32'hDEAD_BEEF;
        chk("hdr_ready_load", {63'd0, hdr_ready}, 64'd1);
        tick();
      end
    end
    hdr_valid = 1'b0;
  endtask

  task automatic wait_result();
    int start;
    bit got;
    start = results_seen;
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      tick();
      if (results_seen > start) got = 1'b1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL result_wait: got no result_valid, expected one within 300 cycles");
    end
    tick(); tick();
  endtask

  task automatic run_job(input logic [15:0] hb, input logic [15:0] ob, input logic [31:0] tg,
                         input logic [31:0] hval, input bit toggle, input res_t r);
    rq.push_back(r);
    start_job(hb, ob, tg);
    send_header(hb, hval, toggle);
    wait_result();
  endtask

  logic [31:0] v [N];
  bit seen_kick;

  initial begin
    repeat (3) tick();
    chk("reset_ctrl", {57'd0, busy, hdr_ready, hash_start, mem_we, result_valid, found, timeout}, 64'd0);
    chk("reset_data", {mem_addr, mem_wdata, best_nonce, 12'd0}, 64'd0);
    chk("reset_hash", {32'd0, best_hash}, 64'd0);
    reset = 1'b0;
    tick();

    // Minimum with a tie at 5: lower index wins, 5 < 6 is found.
    for (int j = 0; j < N; j++) v[j] = 32'hF;
    v[0] = 32'h9; v[1] = 32'h5; v[2] = 32'h7; v[3] = 32'h5;
    preload(16'h0100, v);
    run_job(16'h0000, 16'h0100, 32'h6, 32'h0, 1'b0,
            '{fnd: 1'b1, nonce: 4'd1, hash: 32'h5, to: 1'b0, lat: H + 19});

    // Toggled header valid; all-ones result against all-ones target is not found.
    for (int j = 0; j < N; j++) v[j] = 32'hFFFF_FFFF;
    preload(16'h0300, v);
    run_job(16'h0200, 16'h0300, 32'hFFFF_FFFF, 32'h1000_0000, 1'b1,
            '{fnd: 1'b0, nonce: 4'd0, hash: 32'hFFFF_FFFF, to: 1'b0, lat: H + 19});

    // Result region wraps past 0xFFFF; the minimum sits at 0x0002 (index 10).
    for (int j = 0; j < N; j++) v[j] = 32'd100 + 32'(j);
    v[10] = 32'd3;
    preload(16'hFFF8, v);
    run_job(16'h1000, 16'hFFF8, 32'h10, 32'h2000_0000, 1'b0,
            '{fnd: 1'b1, nonce: 4'd10, hash: 32'd3, to: 1'b0, lat: H + 19});

    // Hasher never leaves idle: abort after TO wait cycles.
    hasher_en = 1'b0;
    run_job(16'h2000, 16'h0100, 32'hFFFF_FFFF, 32'h3000_0000, 1'b0,
            '{fnd: 1'b0, nonce: 4'd0, hash: 32'h0, to: 1'b1, lat: TO + 1});
    hasher_en = 1'b1;

    // Reset in the middle of READ with job_start held, then a fresh job.
    start_job(16'h3000, 16'h0100, 32'h6);
    send_header(16'h3000, 32'h4000_0000, 1'b0);
    seen_kick = 1'b0;
    for (int c = 0; c < 20 && !seen_kick; c++) begin
      if (hash_start) seen_kick = 1'b1;
      tick();
    end
    chk("kick_seen", {63'd0, seen_kick}, 64'd1);
    repeat (H + 6) tick();
    reset = 1'b1; job_start = 1'b1;
    header_addr = 16'h4000; hash_out_addr = 16'h0100; target = 32'h6;
    exp_kick_addr = 16'h4012;
    tick();
    chk("midreset_ctrl", {57'd0, busy, hdr_ready, hash_start, mem_we, result_valid, found, timeout}, 64'd0);
    chk("midreset_data", {mem_addr, mem_wdata, best_nonce, 12'd0}, 64'd0);
    reset = 1'b0;
    rq.push_back('{fnd: 1'b1, nonce: 4'd1, hash: 32'h5, to: 1'b0, lat: H + 19});
    tick();
    job_start = 1'b0;
    chk("restart_busy", {62'd0, busy, hdr_ready}, 64'd3);
    send_header(16'h4000, 32'h5000_0000, 1'b0);
    wait_result();

    if (wq.size() != 0 || rq.size() != 0) begin
      checks++; errors++;
      $display("FAIL leftover: writes %0d results %0d pending, expected 0", wq.size(), rq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
